// File: rtl/imager_arbiter.sv
// Round-robin arbiter sharing one camera between flight FSM, ground station and
// maintenance, with start/capture/cooldown sequencing and a capture timeout.
module imager_arbiter #(
  parameter int TIMEOUT_CYCLES  = 1000,
  parameter int COOLDOWN_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       abort,
  input  logic       cam_ready,
  input  logic       cam_done,
  input  logic [1:0] cam_pass,
  output logic       cam_start,
  output logic [2:0] gnt,
  output logic [2:0] done,
  output logic [1:0] result,
  output logic       timeout_err,
  output logic       busy,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    CAPTURE  = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LAST = CNT_W'(COOLDOWN_CYCLES - 1);

  localparam logic [1:0] RES_PASS  = 2'b10;
  localparam logic [1:0] RES_FAIL  = 2'b01;
  localparam logic [1:0] RES_ABORT = 2'b00;

  state_t           state_q, state_d;
  logic [1:0]       win_q, win_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       gnt_d, done_d;
  logic             cam_start_d;
  logic [1:0]       result_d;
  logic             timeout_err_d;

  logic [1:0]       pick;
  logic             finish;
  logic [1:0]       fin_result;
  logic             fin_timeout;

  // First requester found when searching upward (mod 3) from the pointer.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] p);
    logic [1:0] w;
    w = 2'd0;
    case (p)
      2'd1: begin
        if (r[1])      w = 2'd1;
        else if (r[2]) w = 2'd2;
        else           w = 2'd0;
      end
      2'd2: begin
        if (r[2])      w = 2'd2;
        else if (r[0]) w = 2'd0;
        else           w = 2'd1;
      end
      default: begin
        if (r[0])      w = 2'd0;
        else if (r[1]) w = 2'd1;
        else           w = 2'd2;
      end
    endcase
    return w;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    logic [2:0] v;
    case (idx)
      2'd0:    v = 3'b001;
      2'd1:    v = 3'b010;
      default: v = 3'b100;
    endcase
    return v;
  endfunction

  assign pick = rr_pick(req, ptr_q);

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d       = state_q;
    win_d         = win_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt;
    done_d        = 3'b000;
    cam_start_d   = 1'b0;
    result_d      = result;
    timeout_err_d = timeout_err;
    finish        = 1'b0;
    fin_result    = RES_ABORT;
    fin_timeout   = 1'b0;

    case (state_q)
      IDLE: begin
        gnt_d = 3'b000;
        if ((|req) && cam_ready && !abort) begin
          win_d         = pick;
          gnt_d         = onehot(pick);
          cam_start_d   = 1'b1;
          timeout_err_d = 1'b0;
          ptr_d         = (pick == 2'd2) ? 2'd0 : pick + 2'd1;
          state_d       = START;
        end
      end

      START: begin
        cnt_d = '0;
        if (abort) begin
          finish     = 1'b1;
          fin_result = RES_ABORT;
        end else begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (abort) begin
          finish     = 1'b1;
          fin_result = RES_ABORT;
        end else if (cam_done) begin
          // A malformed verdict is treated as a failure.
          finish     = 1'b1;
          fin_result = (cam_pass == RES_PASS || cam_pass == RES_FAIL) ? cam_pass : RES_FAIL;
        end else if (cnt_q == TIMEOUT_LAST) begin
          finish      = 1'b1;
          fin_result  = RES_FAIL;
          fin_timeout = 1'b1;
        end
      end

      COOLDOWN: begin
        gnt_d = 3'b000;
        if (cnt_q == COOLDOWN_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    // Common completion path: done pulse and verdict land on the first COOLDOWN cycle.
    if (finish) begin
      state_d       = COOLDOWN;
      cnt_d         = '0;
      gnt_d         = 3'b000;
      done_d        = onehot(win_q);
      result_d      = fin_result;
      timeout_err_d = fin_timeout;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      win_q       <= 2'd0;
      ptr_q       <= 2'd0;
      cnt_q       <= '0;
      gnt         <= 3'b000;
      done        <= 3'b000;
      cam_start   <= 1'b0;
      result      <= RES_ABORT;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      gnt         <= gnt_d;
      done        <= done_d;
      cam_start   <= cam_start_d;
      result      <= result_d;
      timeout_err <= timeout_err_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign state_out = state_q;

endmodule

// File: tb/tb_imager_arbiter.sv
// Self-checking bench for imager_arbiter: directed scenarios plus randomized
// captures checked against a transaction-level round-robin/verdict model.
module tb_imager_arbiter;

  localparam int TO = 1000;
  localparam int CD = 4;

  localparam int M_DONE    = 0;
  localparam int M_ABORT   = 1;
  localparam int M_TIMEOUT = 2;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic       abort;
  logic       cam_ready;
  logic       cam_done;
  logic [1:0] cam_pass;
  logic       cam_start;
  logic [2:0] gnt;
  logic [2:0] done;
  logic [1:0] result;
  logic       timeout_err;
  logic       busy;
  logic [1:0] state_out;

  int         n_asserts;
  int         n_fails;
  int         ptr_m;
  logic [1:0] exp_result;
  logic       exp_to;

  imager_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .COOLDOWN_CYCLES(CD),
    .CNT_W          (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .abort      (abort),
    .cam_ready  (cam_ready),
    .cam_done   (cam_done),
    .cam_pass   (cam_pass),
    .cam_start  (cam_start),
    .gnt        (gnt),
    .done       (done),
    .result     (result),
    .timeout_err(timeout_err),
    .busy       (busy),
    .state_out  (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin: first requester at or after the pointer, wrapping mod 3.
  function automatic int model_pick(input logic [2:0] r);
    int  w;
    bit  found;
    w = -1;
    found = 1'b0;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (ptr_m + k) % 3;
      if (!found && (((r >> idx) & 3'b001) != 3'b000)) begin
        w = idx;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  // One full transaction from IDLE to IDLE. k = capture cycle on which the
  // camera answers or abort arrives (abort with k=0 means during START).
  task automatic run_capture(input string tag, input logic [2:0] r, input int mode, input int k,
                             input logic [1:0] pass, input bit hold, input bit noise);
    int         w;
    logic [2:0] w_oh;
    req = r;
    cam_ready = 1'b1;
    w = model_pick(r);
    w_oh = 3'(1 << w);
    tick();
    check({tag, ":start_state"}, 32'(state_out), 1);
    check({tag, ":start_gnt"}, 32'(gnt), 32'(w_oh));
    check({tag, ":start_cam_start"}, 32'(cam_start), 1);
    check({tag, ":start_busy"}, 32'(busy), 1);
    check({tag, ":start_to_clr"}, 32'(timeout_err), 0);
    check({tag, ":start_result_hold"}, 32'(result), 32'(exp_result));
    ptr_m = (w + 1) % 3;
    if (!hold) req = 3'b000;

    if (mode == M_ABORT && k == 0) begin
      abort = 1'b1;
      tick();
    end else begin
      for (int c = 1; c <= TO; c++) begin
        tick();
        check({tag, ":cap_state"}, 32'(state_out), 2);
        check({tag, ":cap_gnt"}, 32'(gnt), 32'(w_oh));
        check({tag, ":cap_cam_start"}, 32'(cam_start), 0);
        if (mode == M_DONE && c == k) begin
          cam_done = 1'b1;
          cam_pass = pass;
        end
        if (mode == M_ABORT && c == k) abort = 1'b1;
        if (mode != M_TIMEOUT && c == k) break;
      end
      tick();
    end
    cam_done = 1'b0;
    abort = 1'b0;

    case (mode)
      M_DONE: begin
        exp_result = (pass == 2'b10 || pass == 2'b01) ? pass : 2'b01;
        exp_to = 1'b0;
      end
      M_ABORT: begin
        exp_result = 2'b00;
        exp_to = 1'b0;
      end
      default: begin
        exp_result = 2'b01;
        exp_to = 1'b1;
      end
    endcase

    check({tag, ":cd_state"}, 32'(state_out), 3);
    check({tag, ":cd_gnt"}, 32'(gnt), 0);
    check({tag, ":cd_done"}, 32'(done), 32'(w_oh));
    check({tag, ":cd_result"}, 32'(result), 32'(exp_result));
    check({tag, ":cd_timeout_err"}, 32'(timeout_err), 32'(exp_to));
    check({tag, ":cd_busy"}, 32'(busy), 1);

    for (int c = 2; c <= CD; c++) begin
      if (noise) begin
        cam_done = 1'b1;
        cam_pass = 2'($urandom_range(3, 0));
      end
      tick();
      check({tag, ":cd_hold_state"}, 32'(state_out), 3);
      check({tag, ":cd_done_once"}, 32'(done), 0);
      check({tag, ":cd_hold_result"}, 32'(result), 32'(exp_result));
      check({tag, ":cd_hold_gnt"}, 32'(gnt), 0);
    end
    cam_done = 1'b0;
    tick();
    check({tag, ":idle_state"}, 32'(state_out), 0);
    check({tag, ":idle_busy"}, 32'(busy), 0);
    check({tag, ":idle_gnt"}, 32'(gnt), 0);
    check({tag, ":idle_result"}, 32'(result), 32'(exp_result));
    check({tag, ":idle_timeout_err"}, 32'(timeout_err), 32'(exp_to));
  endtask

  task automatic idle_blocked(input string tag, input logic [2:0] r, input logic ab,
                              input logic rdy, input int n);
    req = r;
    abort = ab;
    cam_ready = rdy;
    for (int i = 0; i < n; i++) begin
      tick();
      check({tag, ":state"}, 32'(state_out), 0);
      check({tag, ":gnt"}, 32'(gnt), 0);
      check({tag, ":cam_start"}, 32'(cam_start), 0);
    end
    req = 3'b000;
    abort = 1'b0;
    cam_ready = 1'b1;
  endtask

  initial begin
    int         mode;
    int         k;
    logic [2:0] r;
    logic [1:0] pass;
    bit         hold;
    bit         noise;

    n_asserts = 0;
    n_fails = 0;
    ptr_m = 0;
    exp_result = 2'b00;
    exp_to = 1'b0;

    reset = 1'b1;
    req = 3'b000;
    abort = 1'b0;
    cam_ready = 1'b0;
    cam_done = 1'b0;
    cam_pass = 2'b00;
    tick();
    check("reset:gnt", 32'(gnt), 0);
    check("reset:cam_start", 32'(cam_start), 0);
    check("reset:done", 32'(done), 0);
    check("reset:result", 32'(result), 0);
    check("reset:timeout_err", 32'(timeout_err), 0);
    check("reset:busy", 32'(busy), 0);
    check("reset:state", 32'(state_out), 0);
    reset = 1'b0;
    tick();

    // req=111 held: grants rotate 001, 010, 100, 001.
    for (int i = 0; i < 4; i++) begin
      int         w_exp;
      logic [2:0] order;
      order = 3'b111;
      w_exp = model_pick(order);
      check("rr:order", 32'(w_exp), 32'(i % 3));
      run_capture("rr", 3'b111, M_DONE, 3, 2'b10, 1'b1, 1'b0);
    end
    req = 3'b000;

    run_capture("single_pass", 3'b001, M_DONE, 5, 2'b10, 1'b1, 1'b0);
    req = 3'b000;

    run_capture("timeout", 3'b010, M_TIMEOUT, 0, 2'b00, 1'b0, 1'b0);
    run_capture("done_on_last", 3'b010, M_DONE, TO, 2'b10, 1'b0, 1'b0);
    run_capture("abort_cap3", 3'b100, M_ABORT, 3, 2'b00, 1'b0, 1'b1);
    run_capture("abort_start", 3'b001, M_ABORT, 0, 2'b00, 1'b0, 1'b0);
    run_capture("bad_verdict", 3'b110, M_DONE, 2, 2'b11, 1'b0, 1'b1);

    idle_blocked("abort_idle", 3'b001, 1'b1, 1'b1, 3);
    idle_blocked("not_ready", 3'b100, 1'b0, 1'b0, 3);

    for (int t = 0; t < 24; t++) begin
      r     = 3'($urandom_range(7, 1));
      mode  = int'($urandom_range(1, 0));
      k     = (mode == M_ABORT) ? int'($urandom_range(6, 0)) : int'($urandom_range(8, 1));
      pass  = 2'($urandom_range(3, 0));
      hold  = 1'($urandom_range(1, 0));
      noise = 1'($urandom_range(1, 0));
      if ($urandom_range(3, 0) == 0) idle_blocked("rand_gate", 3'($urandom_range(7, 0)), 1'b0, 1'b0, 2);
      run_capture("rand", r, mode, k, pass, hold, noise);
      req = 3'b000;
    end

    // Reset in the middle of a capture; the pointer must return to requester 0.
    req = 3'b001;
    cam_ready = 1'b1;
    tick();
    check("rst_mid:gnt_before", 32'(gnt), 32'(3'b001));
    req = 3'b000;
    tick();
    tick();
    check("rst_mid:in_capture", 32'(state_out), 2);
    reset = 1'b1;
    #1;
    check("rst_mid:gnt", 32'(gnt), 0);
    check("rst_mid:state", 32'(state_out), 0);
    check("rst_mid:cam_start", 32'(cam_start), 0);
    check("rst_mid:result", 32'(result), 0);
    ptr_m = 0;
    exp_result = 2'b00;
    exp_to = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_capture("post_reset", 3'b111, M_DONE, 2, 2'b01, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
